// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: result-source select, load widths and FSM state.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LH  = 3'd1,
    LD_LW  = 3'd2,
    LD_LBU = 3'd4,
    LD_LHU = 3'd5
  } load_type_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load data extraction: picks the byte/half/word addressed by addr_lo
// out of the low memory word and sign- or zero-extends it to WIDTH.
module load_align
  import wb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       addr_lo_in,
  input  logic [2:0]       load_type_in,
  output logic [WIDTH-1:0] result_out
);

  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_word = data_in[31:0];
  assign w_byte = w_word[{addr_lo_in, 3'b000} +: 8];
  // Halfword selection ignores addr_lo[0]; misaligned halves are not split.
  assign w_half = w_word[{addr_lo_in[1], 4'b0000} +: 16];

  always_comb begin
    result_out = WIDTH'($signed(w_word));
    case (load_type_in)
      LD_LB:   result_out = WIDTH'($signed(w_byte));
      LD_LH:   result_out = WIDTH'($signed(w_half));
      LD_LBU:  result_out = WIDTH'(w_byte);
      LD_LHU:  result_out = WIDTH'(w_half);
      default: result_out = WIDTH'($signed(w_word));
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: single-entry holding register in front of the register-file
// write port, with forwarding of the held result and a retired-instruction counter.
//
// state    | meaning
// ST_EMPTY | no entry held, stage always ready
// ST_FULL  | one resolved result held, drains when rf_ready_in=1
module wb_stage
  import wb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              flush_in,
  input  logic [1:0]        wb_sel_in,
  input  logic [2:0]        load_type_in,
  input  logic [1:0]        addr_lo_in,
  input  logic [WIDTH-1:0]  mem_data_in,
  input  logic [WIDTH-1:0]  alu_res_in,
  input  logic [WIDTH-1:0]  pc4_in,
  input  logic [WIDTH-1:0]  imm_in,
  input  logic [REG_AW-1:0] rd_addr_in,
  input  logic              reg_write_in,
  input  logic              rf_ready_in,
  output logic              rf_we_out,
  output logic [REG_AW-1:0] rf_addr_out,
  output logic [WIDTH-1:0]  rf_data_out,
  output logic              fwd_valid_out,
  output logic [REG_AW-1:0] fwd_addr_out,
  output logic [WIDTH-1:0]  fwd_data_out,
  output logic [31:0]       retire_cnt_out
);

  wb_state_e         r_state;
  logic [WIDTH-1:0]  r_data;
  logic [REG_AW-1:0] r_rd;
  logic              r_rw;
  logic [31:0]       r_cnt;

  logic              w_full;
  logic              w_ready;
  logic              w_capture;
  logic              w_drain;
  logic              w_dest_ok;
  logic [WIDTH-1:0]  w_mem_res;
  logic [WIDTH-1:0]  w_result;

  load_align #(.WIDTH(WIDTH)) u_align (
    .data_in      (mem_data_in),
    .addr_lo_in   (addr_lo_in),
    .load_type_in (load_type_in),
    .result_out   (w_mem_res)
  );

  always_comb begin
    w_result = alu_res_in;
    case (wb_sel_in)
      WB_ALU:  w_result = alu_res_in;
      WB_MEM:  w_result = w_mem_res;
      WB_PC4:  w_result = pc4_in;
      WB_IMM:  w_result = imm_in;
      default: w_result = alu_res_in;
    endcase
  end

  assign w_full    = (r_state == ST_FULL);
  assign w_ready   = !w_full || rf_ready_in;
  // Flush wins over both capture and drain in the same cycle.
  assign w_capture = valid_in && w_ready && !flush_in;
  assign w_drain   = w_full && rf_ready_in && !flush_in;
  assign w_dest_ok = r_rw && (r_rd != '0);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_rd    <= '0;
      r_rw    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_drain)
        r_cnt <= r_cnt + 32'd1;
      if (flush_in) begin
        r_state <= ST_EMPTY;
      end else if (w_capture) begin
        r_state <= ST_FULL;
        r_data  <= w_result;
        r_rd    <= rd_addr_in;
        r_rw    <= reg_write_in;
      end else if (w_drain) begin
        r_state <= ST_EMPTY;
      end
    end
  end

  assign ready_out      = w_ready;
  assign rf_we_out      = w_full && w_dest_ok && rf_ready_in && !flush_in;
  assign rf_addr_out    = r_rd;
  assign rf_data_out    = r_data;
  assign fwd_valid_out  = w_full && w_dest_ok;
  assign fwd_addr_out   = r_rd;
  assign fwd_data_out   = r_data;
  assign retire_cnt_out = r_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: single-instruction vector table plus hand-written
// back-to-back, stall, flush and mid-stall reset sequences.
module tb_wb_stage;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic        ready_out;
  logic        flush_in;
  logic [1:0]  wb_sel_in;
  logic [2:0]  load_type_in;
  logic [1:0]  addr_lo_in;
  logic [31:0] mem_data_in;
  logic [31:0] alu_res_in;
  logic [31:0] pc4_in;
  logic [31:0] imm_in;
  logic [4:0]  rd_addr_in;
  logic        reg_write_in;
  logic        rf_ready_in;
  logic        rf_we_out;
  logic [4:0]  rf_addr_out;
  logic [31:0] rf_data_out;
  logic        fwd_valid_out;
  logic [4:0]  fwd_addr_out;
  logic [31:0] fwd_data_out;
  logic [31:0] retire_cnt_out;

  wb_stage #(.WIDTH(32), .REG_AW(5)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .flush_in       (flush_in),
    .wb_sel_in      (wb_sel_in),
    .load_type_in   (load_type_in),
    .addr_lo_in     (addr_lo_in),
    .mem_data_in    (mem_data_in),
    .alu_res_in     (alu_res_in),
    .pc4_in         (pc4_in),
    .imm_in         (imm_in),
    .rd_addr_in     (rd_addr_in),
    .reg_write_in   (reg_write_in),
    .rf_ready_in    (rf_ready_in),
    .rf_we_out      (rf_we_out),
    .rf_addr_out    (rf_addr_out),
    .rf_data_out    (rf_data_out),
    .fwd_valid_out  (fwd_valid_out),
    .fwd_addr_out   (fwd_addr_out),
    .fwd_data_out   (fwd_data_out),
    .retire_cnt_out (retire_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  lt;
    logic [1:0]  alo;
    logic [31:0] mem;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] exp_data;
    logic        exp_we;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vec [NVEC];

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    vec[0]  = '{2'd1, 3'd0, 2'd3, 32'h80FF_1234, 5'd5,  1'b1, 32'hFFFF_FF80, 1'b1}; // LB
    vec[1]  = '{2'd1, 3'd5, 2'd2, 32'h9ABC_0000, 5'd6,  1'b1, 32'h0000_9ABC, 1'b1}; // LHU
    vec[2]  = '{2'd1, 3'd1, 2'd2, 32'h9ABC_0000, 5'd6,  1'b1, 32'hFFFF_9ABC, 1'b1}; // LH
    vec[3]  = '{2'd1, 3'd1, 2'd3, 32'h9ABC_0000, 5'd7,  1'b1, 32'hFFFF_9ABC, 1'b1}; // LH, bit0 ignored
    vec[4]  = '{2'd1, 3'd4, 2'd1, 32'h0000_F500, 5'd8,  1'b1, 32'h0000_00F5, 1'b1}; // LBU
    vec[5]  = '{2'd1, 3'd2, 2'd0, 32'hDEAD_BEEF, 5'd9,  1'b1, 32'hDEAD_BEEF, 1'b1}; // LW
    vec[6]  = '{2'd1, 3'd3, 2'd1, 32'h1234_5678, 5'd10, 1'b1, 32'h1234_5678, 1'b1}; // odd code -> LW
    vec[7]  = '{2'd0, 3'd0, 2'd0, 32'h0000_0000, 5'd11, 1'b1, 32'h1111_1111, 1'b1}; // ALU
    vec[8]  = '{2'd2, 3'd0, 2'd0, 32'h0000_0000, 5'd0,  1'b1, 32'h2222_2222, 1'b0}; // PC4 to x0
    vec[9]  = '{2'd3, 3'd0, 2'd0, 32'h0000_0000, 5'd31, 1'b0, 32'h3333_3333, 1'b0}; // IMM, no write
    vec[10] = '{2'd1, 3'd1, 2'd0, 32'hFFFF_7FFF, 5'd12, 1'b1, 32'h0000_7FFF, 1'b1}; // LH positive
    vec[11] = '{2'd1, 3'd0, 2'd0, 32'hFFFF_FF7F, 5'd13, 1'b1, 32'h0000_007F, 1'b1}; // LB positive

    rst_in = 1'b1; valid_in = 1'b0; flush_in = 1'b0; wb_sel_in = 2'd0;
    load_type_in = 3'd0; addr_lo_in = 2'd0; mem_data_in = '0;
    alu_res_in = 32'h1111_1111; pc4_in = 32'h2222_2222; imm_in = 32'h3333_3333;
    rd_addr_in = '0; reg_write_in = 1'b0; rf_ready_in = 1'b1;
    exp_cnt = 0;
    #1;
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_we", 32'(rf_we_out), 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid_out), 32'd0);
    chk("rst_cnt", retire_cnt_out, 32'd0);
    chk("rst_addr", 32'(rf_addr_out), 32'd0);
    chk("rst_data", rf_data_out, 32'd0);

    @(negedge clk_in);
    rst_in = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk_in);
      valid_in = 1'b1; wb_sel_in = vec[i].sel; load_type_in = vec[i].lt;
      addr_lo_in = vec[i].alo; mem_data_in = vec[i].mem;
      rd_addr_in = vec[i].rd; reg_write_in = vec[i].rw;
      @(negedge clk_in);
      valid_in = 1'b0;
      chk($sformatf("v%0d_data", i), rf_data_out, vec[i].exp_data);
      chk($sformatf("v%0d_we", i), 32'(rf_we_out), 32'(vec[i].exp_we));
      chk($sformatf("v%0d_addr", i), 32'(rf_addr_out), 32'(vec[i].rd));
      chk($sformatf("v%0d_fwd_valid", i), 32'(fwd_valid_out), 32'(vec[i].exp_we));
      chk($sformatf("v%0d_fwd_data", i), fwd_data_out, vec[i].exp_data);
      @(negedge clk_in);
      exp_cnt = exp_cnt + 1;
      chk($sformatf("v%0d_cnt", i), retire_cnt_out, exp_cnt);
      chk($sformatf("v%0d_empty_we", i), 32'(rf_we_out), 32'd0);
    end

    // back-to-back ALU results 1..4, no bubbles
    wb_sel_in = 2'd0; reg_write_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      valid_in = 1'b1; alu_res_in = 32'(i); rd_addr_in = 5'(i);
      @(negedge clk_in);
      chk($sformatf("b2b%0d_we", i), 32'(rf_we_out), 32'd1);
      chk($sformatf("b2b%0d_data", i), rf_data_out, 32'(i));
      chk($sformatf("b2b%0d_ready", i), 32'(ready_out), 32'd1);
    end
    valid_in = 1'b0;
    @(negedge clk_in);
    exp_cnt = exp_cnt + 4;
    chk("b2b_cnt", retire_cnt_out, exp_cnt);

    // stall three cycles, newer valid input must not displace the held entry
    valid_in = 1'b1; alu_res_in = 32'h55; rd_addr_in = 5'd7; rf_ready_in = 1'b0;
    @(negedge clk_in);
    alu_res_in = 32'h66;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_ready", k), 32'(ready_out), 32'd0);
      chk($sformatf("stall%0d_fwd_valid", k), 32'(fwd_valid_out), 32'd1);
      chk($sformatf("stall%0d_fwd_data", k), fwd_data_out, 32'h55);
      chk($sformatf("stall%0d_we", k), 32'(rf_we_out), 32'd0);
      chk($sformatf("stall%0d_cnt", k), retire_cnt_out, exp_cnt);
      @(negedge clk_in);
    end
    rf_ready_in = 1'b1; valid_in = 1'b0;
    #1;
    chk("release_we", 32'(rf_we_out), 32'd1);
    chk("release_data", rf_data_out, 32'h55);
    @(negedge clk_in);
    exp_cnt = exp_cnt + 1;
    chk("release_cnt", retire_cnt_out, exp_cnt);
    chk("release_after_we", 32'(rf_we_out), 32'd0);
    chk("release_after_fwd", 32'(fwd_valid_out), 32'd0);

    // flush with FULL and a valid input pending
    valid_in = 1'b1; alu_res_in = 32'h77; rd_addr_in = 5'd3;
    @(negedge clk_in);
    chk("flush_pre_fwd", 32'(fwd_valid_out), 32'd1);
    flush_in = 1'b1; alu_res_in = 32'h88;
    #1;
    chk("flush_we", 32'(rf_we_out), 32'd0);
    @(negedge clk_in);
    flush_in = 1'b0; valid_in = 1'b0;
    chk("flush_fwd", 32'(fwd_valid_out), 32'd0);
    chk("flush_we_next", 32'(rf_we_out), 32'd0);
    chk("flush_ready", 32'(ready_out), 32'd1);
    chk("flush_cnt", retire_cnt_out, exp_cnt);

    // reset in the middle of a stall
    valid_in = 1'b1; alu_res_in = 32'h99; rd_addr_in = 5'd9; rf_ready_in = 1'b0;
    @(negedge clk_in);
    valid_in = 1'b0;
    chk("mrst_pre_fwd", 32'(fwd_valid_out), 32'd1);
    #2 rst_in = 1'b1;
    #1;
    chk("mrst_ready", 32'(ready_out), 32'd1);
    chk("mrst_we", 32'(rf_we_out), 32'd0);
    chk("mrst_fwd_valid", 32'(fwd_valid_out), 32'd0);
    chk("mrst_fwd_addr", 32'(fwd_addr_out), 32'd0);
    chk("mrst_fwd_data", fwd_data_out, 32'd0);
    chk("mrst_data", rf_data_out, 32'd0);
    chk("mrst_cnt", retire_cnt_out, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0; rf_ready_in = 1'b1;
    #1;
    chk("mrst_post_we", 32'(rf_we_out), 32'd0);
    @(negedge clk_in);
    chk("mrst_post_cnt", retire_cnt_out, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; SHALL be 32 or 64.
REQ-002 Parameter REG_AW, default 5, register-address width.
REQ-003 One clock; reset is asynchronous and active-high: clk_in input 1, rising-edge clock; rst_in input 1, asynchronous active-high reset.
REQ-004 valid_in input 1: MEM stage presents an instruction.
REQ-005 ready_out output 1: stage accepts this cycle.
REQ-006 flush_in input 1: discard the held entry.
REQ-007 wb_sel_in input 2: result source, ALU=0, MEM=1, PC4=2, IMM=3.
REQ-008 load_type_in input 3: LB=0, LH=1, LW=2, LBU=4, LHU=5; other codes behave as LW.
REQ-009 addr_lo_in input 2: low bits of the load address.
REQ-010 mem_data_in, alu_res_in, pc4_in, imm_in input WIDTH each: candidate results.
REQ-011 rd_addr_in input REG_AW, reg_write_in input 1: destination and write intent.
REQ-012 rf_ready_in input 1: register-file write port available.
REQ-013 rf_we_out output 1, rf_addr_out output REG_AW, rf_data_out output WIDTH: register-file write port.
REQ-014 fwd_valid_out output 1, fwd_addr_out output REG_AW, fwd_data_out output WIDTH: forwarding of the held result.
REQ-015 retire_cnt_out output 32: count of retired instructions.

Function
REQ-016 The stage SHALL hold one entry and use a two-state FSM, EMPTY and FULL.
REQ-017 ready_out SHALL be 1 in EMPTY, and in FULL only when rf_ready_in=1.
REQ-018 A capture SHALL occur when valid_in=1 and ready_out=1; the resolved result SHALL be registered, giving a latency of one cycle from input to rf_data_out.
REQ-019 Result SHALL be alu_res_in, aligned/extended mem_data_in, pc4_in or imm_in per wb_sel_in.
REQ-020 Byte loads SHALL select byte addr_lo_in; halfword loads SHALL select half addr_lo_in[1] and ignore addr_lo_in[0]; LB/LH sign-extend, LBU/LHU zero-extend to WIDTH.
REQ-021 LW at WIDTH=64 SHALL take word addr_lo_in[1]... no: word 0, sign-extended; at WIDTH=32, LW passes the data unchanged.
REQ-022 rf_we_out SHALL equal FULL and held reg_write and held rd!=0 and rf_ready_in; writes to x0 are suppressed.
REQ-023 Drain: FULL with rf_ready_in=1 retires the entry; simultaneous capture keeps FULL with the new entry (no bubble), otherwise go EMPTY.
REQ-024 FULL with rf_ready_in=0 SHALL hold all outputs stable, with ready_out=0.
REQ-025 fwd_valid_out SHALL be FULL and held reg_write and held rd!=0, independent of rf_ready_in; fwd_addr_out/fwd_data_out equal the held rd/result.
REQ-026 flush_in SHALL force EMPTY next cycle, suppress rf_we_out in that cycle, and block capture that cycle; it has priority over capture and drain.
REQ-027 retire_cnt_out SHALL increment by 1 on each drain (including x0 and reg_write=0 entries), wrapping 0xFFFFFFFF to 0; flushed entries are not counted.

Reset
REQ-028 rst_in SHALL immediately force EMPTY, ready_out=1, rf_we_out=0, fwd_valid_out=0, retire_cnt_out=0, rf_addr_out/fwd_addr_out=0, rf_data_out/fwd_data_out=0.
REQ-029 Reset asserted mid-operation SHALL discard the held entry with no write issued.

Structure
REQ-030 Package wb_pkg SHALL hold the wb_sel_e and load_type_e enums and the FSM state type.
REQ-031 Sub-module load_align (data, addr_lo, load_type -> WIDTH result) SHALL hold the extraction and extension logic; it is combinational, and the FSM and register live in wb_stage.

Verification
REQ-032 LB, addr_lo=3, mem=0x80FF_1234, rd=5 -> next cycle rf_we=1, rf_addr=5, rf_data=0xFFFF_FF80.
REQ-033 LHU, addr_lo=2, mem=0x9ABC_0000 -> rf_data=0x0000_9ABC; LH with the same inputs -> 0xFFFF_9ABC.
REQ-034 Back-to-back valid with rf_ready=1 for 4 cycles, sel=ALU, values 1..4 -> writes 1,2,3,4 on consecutive cycles, retire_cnt=4.
REQ-035 FULL with rf_ready=0 for 3 cycles -> ready_out=0, fwd_valid=1 with data held, rf_we=0; on release, one write.
REQ-036 rd=0, reg_write=1, sel=PC4 -> rf_we=0, fwd_valid=0, retire_cnt increments.
REQ-037 flush_in with FULL and valid_in=1 -> next cycle EMPTY, no write, count unchanged; rst_in mid-stall -> all outputs zero immediately.
